// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer.
//   alu_sel_e   : ALU opcode encoding driven on o_alu_sel
//   seq_state_e : sequencer FSM states
//   instr_t     : one program word {sel, a}
//   DRAIN_CYCLES: edges from the last operand being presented to its
//                 result being sampled back from the ALU
package alu_seq_pkg;

  localparam int INSTR_W      = 10;
  localparam int DRAIN_CYCLES = 3;

  typedef enum logic [1:0] {
    SEL_ADD = 2'b00,
    SEL_SUB = 2'b01,
    SEL_MAX = 2'b10,
    SEL_MIN = 2'b11
  } alu_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    alu_sel_e    sel;
    logic [7:0]  a;
  } instr_t;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program memory for the ALU op sequencer.
//   i_clk      : write clock
//   i_wr_en    : write strobe (already qualified by the caller)
//   i_wr_addr  : write address
//   i_wr_data  : instruction to store
//   i_rd_addr  : read address
//   o_rd_data  : instruction at i_rd_addr (combinational read)
// Flop array with no reset: contents survive i_reset. A write at an edge is
// visible on the read port in the following cycle.
module alu_seq_prog_mem
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  instr_t        i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output instr_t        o_rd_data
);

  instr_t mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the registered accumulator ALU.
//   i_clk, i_reset           : clock, async active-high reset
//   i_wr_en/i_wr_addr/i_wr_data : program write port (accepted only in IDLE)
//   i_len, i_start           : run request (length 1..DEPTH), sampled in IDLE
//   o_busy, o_done, o_err    : status; o_done/o_err are one-cycle pulses
//   o_final, o_carry_seen, o_ovf_seen : last sampled result and sticky flags
//   o_alu_a, o_alu_sel       : operand / opcode stream into the ALU
//   i_alu_result/carry/ovf   : ALU registered result and flags
//
// Request protocol: a run is accepted when i_start is high in IDLE with a
// legal i_len; o_busy then stays high up to and including the o_done cycle.
// Any i_start or i_wr_en seen while busy, or a start with an illegal length,
// produces a single o_err pulse the following cycle and is otherwise ignored.
//
// Timing, start accepted at edge E: operand k is on o_alu_a in the cycle
// after edge E+k, its opcode follows one cycle later (the ALU registers the
// operand first), and its result is sampled at edge E+k+3. The final result
// lands on the edge that enters DONE.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data,
  input  logic [AW:0]        i_len,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [7:0]         o_final,
  output logic               o_carry_seen,
  output logic               o_ovf_seen,
  output logic [7:0]         o_alu_a,
  output logic [1:0]         o_alu_sel,
  input  logic [7:0]         i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_ovf
);

  localparam logic [AW:0] LEN_MAX    = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE    = (AW+1)'(1);
  localparam logic [1:0]  DRAIN_LAST = 2'(DRAIN_CYCLES - 2);

  seq_state_e    state_q, state_d;
  logic [AW:0]   len_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    drain_q;
  alu_sel_e      sel_q;
  logic          iss_d1_q, iss_d2_q;
  logic          err_q;
  logic [7:0]    final_q;
  logic          carry_q, ovf_q;

  logic          idle;
  logic          len_ok;
  logic          start_ok;
  logic          last_issue;
  logic          err_d;
  logic          mem_wr_en;
  instr_t        wr_instr;
  instr_t        rd_instr;

  assign wr_instr = i_wr_data;

  alu_seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .i_clk     (i_clk),
    .i_wr_en   (mem_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (wr_instr),
    .i_rd_addr (idx_q),
    .o_rd_data (rd_instr)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational outputs
  always_comb begin
    state_d    = state_q;
    idle       = (state_q == ST_IDLE);
    len_ok     = (i_len != '0) && (i_len <= LEN_MAX);
    start_ok   = idle && i_start && len_ok;
    last_issue = ({1'b0, idx_q} == (len_q - LEN_ONE));
    err_d      = (i_start && (!idle || !len_ok)) || (i_wr_en && !idle);
    mem_wr_en  = i_wr_en && idle;
    o_busy     = !idle;
    o_done     = (state_q == ST_DONE);
    o_alu_a    = (state_q == ST_ISSUE) ? rd_instr.a : 8'h00;

    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
      // The last ISSUE cycle is the first of the drain window, so only
      // DRAIN_CYCLES-1 cycles are spent here before the result lands.
      ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: index, opcode skew, result sampling
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      len_q    <= '0;
      idx_q    <= '0;
      drain_q  <= '0;
      sel_q    <= SEL_ADD;
      iss_d1_q <= 1'b0;
      iss_d2_q <= 1'b0;
      err_q    <= 1'b0;
      final_q  <= 8'h00;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      err_q <= err_d;

      if (start_ok) begin
        len_q   <= i_len;
        idx_q   <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
      end

      if (state_q == ST_ISSUE) begin
        idx_q   <= idx_q + AW'(1);
        drain_q <= '0;
      end

      if (state_q == ST_DRAIN) begin
        drain_q <= drain_q + 2'd1;
      end

      // Opcode trails its operand by one cycle; ADD of 0 holds the ALU.
      sel_q <= (state_q == ST_ISSUE) ? rd_instr.sel : SEL_ADD;

      // iss_d2_q marks a cycle whose ALU result belongs to this run.
      iss_d1_q <= (state_q == ST_ISSUE);
      iss_d2_q <= iss_d1_q;

      if (iss_d2_q) begin
        final_q <= i_alu_result;
        carry_q <= carry_q | i_alu_carry;
        ovf_q   <= ovf_q | i_alu_ovf;
      end
    end
  end

  assign o_err        = err_q;
  assign o_final      = final_q;
  assign o_carry_seen = carry_q;
  assign o_ovf_seen   = ovf_q;
  assign o_alu_sel    = sel_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural registered ALU attached.
module tb_alu_op_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [9:0]    i_wr_data = '0;
  logic [AW:0]   i_len = '0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done, o_err;
  logic [7:0]    o_final;
  logic          o_carry_seen, o_ovf_seen;
  logic [7:0]    o_alu_a;
  logic [1:0]    o_alu_sel;
  logic [7:0]    alu_acc;
  logic          alu_c, alu_o;
  logic [7:0]    alu_a_q;
  logic [9:0]    alu_nx;

  int total = 0;
  int bad   = 0;

  // program image as written by the host
  logic [7:0] prog_a [DEPTH];
  logic [1:0] prog_s [DEPTH];
  logic [7:0] ref_acc;

  // clock / reset
  always #5 i_clk = ~i_clk;

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_len        (i_len),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_final      (o_final),
    .o_carry_seen (o_carry_seen),
    .o_ovf_seen   (o_ovf_seen),
    .o_alu_a      (o_alu_a),
    .o_alu_sel    (o_alu_sel),
    .i_alu_result (alu_acc),
    .i_alu_carry  (alu_c),
    .i_alu_ovf    (alu_o)
  );

  // One accumulator operation: returns {carry, overflow, result}.
  function automatic logic [9:0] alu_step(input logic [7:0] acc, input logic [7:0] a,
                                          input logic [1:0] sel);
    logic [8:0] s;
    logic [7:0] r;
    logic c, o;
    c = 1'b0;
    o = 1'b0;
    s = '0;
    case (sel)
      2'b00: begin
        s = {1'b0, acc} + {1'b0, a};
        r = s[7:0];
        c = s[8];
        o = (acc[7] == a[7]) && (r[7] != acc[7]);
      end
      2'b01: begin
        s = {1'b0, acc} - {1'b0, a};
        r = s[7:0];
        c = s[8];
        o = (acc[7] != a[7]) && (r[7] != acc[7]);
      end
      2'b10:   r = (acc > a) ? acc : a;
      default: r = (acc < a) ? acc : a;
    endcase
    return {c, o, r};
  endfunction

  // Registered ALU: operand captured one edge, combined with the select the next.
  assign alu_nx = alu_step(alu_acc, alu_a_q, o_alu_sel);
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      alu_a_q <= '0;
      alu_acc <= '0;
      alu_c   <= 1'b0;
      alu_o   <= 1'b0;
    end else begin
      alu_a_q <= o_alu_a;
      alu_acc <= alu_nx[7:0];
      alu_c   <= alu_nx[9];
      alu_o   <= alu_nx[8];
    end
  end

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one program write, called right after a falling edge
  task automatic wr(input int addr, input logic [1:0] s, input logic [7:0] a);
    i_wr_en   = 1'b1;
    i_wr_addr = addr[AW-1:0];
    i_wr_data = {s, a};
    prog_a[addr] = a;
    prog_s[addr] = s;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic wr_random(input int len);
    for (int k = 0; k < len; k++) begin
      wr(k, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
  endtask

  // driver + checker for one run; cycle c counts periods after the start edge
  task automatic run(input int len, input bit inject, input bit sim_wr,
                     input logic [9:0] sim_data, input string tag);
    logic [7:0] sv_a [DEPTH];
    logic [1:0] sv_s [DEPTH];
    logic [7:0] acc;
    logic [9:0] st;
    logic c_seen, o_seen;
    int done_c;
    if (sim_wr) begin
      prog_a[0] = sim_data[7:0];
      prog_s[0] = sim_data[9:8];
      i_wr_en   = 1'b1;
      i_wr_addr = '0;
      i_wr_data = sim_data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      sv_a[k] = prog_a[k];
      sv_s[k] = prog_s[k];
    end
    acc    = ref_acc;
    c_seen = 1'b0;
    o_seen = 1'b0;
    for (int k = 0; k < len; k++) begin
      st     = alu_step(acc, sv_a[k], sv_s[k]);
      acc    = st[7:0];
      c_seen = c_seen | st[9];
      o_seen = o_seen | st[8];
    end
    i_len   = (AW+1)'(len);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_wr_en = 1'b0;
    done_c  = 0;
    for (int c = 1; c <= len + 12 && done_c == 0; c++) begin
      if (c == 1) chk({tag, "_busy_first"}, o_busy, 1);
      if (c <= len) chk({tag, "_a"}, o_alu_a, sv_a[c-1]);
      if (c == len + 1) chk({tag, "_a_idle"}, o_alu_a, 0);
      if (c >= 2 && c <= len + 1) chk({tag, "_sel"}, o_alu_sel, sv_s[c-2]);
      if (c == len + 2) chk({tag, "_sel_idle"}, o_alu_sel, 0);
      if (inject && c == 3) begin
        chk({tag, "_err_busy"}, o_err, 1);
        i_start = 1'b0;
        i_wr_en = 1'b0;
      end
      if (inject && c == 2) begin
        i_start   = 1'b1;
        i_len     = 5'd1;
        i_wr_en   = 1'b1;
        i_wr_addr = '0;
        i_wr_data = ~{sv_s[0], sv_a[0]};
      end
      if (o_done === 1'b1) done_c = c;
      else @(negedge i_clk);
    end
    chk({tag, "_done_cycle"}, done_c, len + 3);
    chk({tag, "_final"}, o_final, acc);
    chk({tag, "_carry"}, o_carry_seen, c_seen);
    chk({tag, "_ovf"}, o_ovf_seen, o_seen);
    chk({tag, "_busy_done"}, o_busy, 1);
    ref_acc = acc;
    @(negedge i_clk);
    chk({tag, "_done_pulse"}, o_done, 0);
    chk({tag, "_busy_after"}, o_busy, 0);
    chk({tag, "_final_hold"}, o_final, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_final"}, o_final, 0);
    chk({tag, "_carry"}, o_carry_seen, 0);
    chk({tag, "_ovf"}, o_ovf_seen, 0);
    chk({tag, "_alu_a"}, o_alu_a, 0);
    chk({tag, "_alu_sel"}, o_alu_sel, 0);
  endtask

  task automatic bad_len(input int len, input string tag);
    i_len   = (AW+1)'(len);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_err"}, o_err, 1);
    chk({tag, "_busy"}, o_busy, 0);
    @(negedge i_clk);
    chk({tag, "_err_pulse"}, o_err, 0);
    chk({tag, "_busy2"}, o_busy, 0);
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    ref_acc = 8'h00;
    #1 i_reset = 1'b1;
    #2 check_reset_outputs("reset_init");
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);

    // basic run from 0
    wr(0, 2'b00, 8'h05);
    wr(1, 2'b00, 8'h07);
    wr(2, 2'b11, 8'h03);
    run(3, 1'b0, 1'b0, 10'h0, "basic");
    chk("basic_lit", o_final, 8'h03);

    // return the accumulator to 0 with MIN 0
    wr(0, 2'b11, 8'h00);
    run(1, 1'b0, 1'b0, 10'h0, "zero1");

    // carry
    wr(0, 2'b00, 8'hFF);
    wr(1, 2'b00, 8'h01);
    run(2, 1'b0, 1'b0, 10'h0, "carry");
    chk("carry_lit", o_carry_seen, 1);

    // flags clear on the next run
    wr(0, 2'b00, 8'h00);
    run(1, 1'b0, 1'b0, 10'h0, "clear");

    // overflow
    wr(0, 2'b00, 8'h7F);
    wr(1, 2'b00, 8'h01);
    run(2, 1'b0, 1'b0, 10'h0, "ovf");
    chk("ovf_lit", o_final, 8'h80);

    // illegal lengths
    bad_len(0, "len0");
    bad_len(DEPTH + 1, "len17");

    // start and write while busy, then rerun the same program
    wr_random(5);
    run(5, 1'b1, 1'b0, 10'h0, "inject");
    run(5, 1'b0, 1'b0, 10'h0, "rerun");

    // write to slot 0 on the same edge as start
    wr_random(4);
    run(4, 1'b0, 1'b1, 10'($urandom_range(0, 1023)), "simwr");

    // random programs
    for (int r = 0; r < 4; r++) begin
      int len;
      len = $urandom_range(1, DEPTH);
      wr_random(len);
      run(len, 1'b0, 1'b0, 10'h0, "rand");
    end

    // reset in the middle of a full-depth run
    wr_random(DEPTH);
    wr(0, 2'b00, 8'h11);
    i_len   = (AW+1)'(DEPTH);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("midrun_busy", o_busy, 1);
    #2 i_reset = 1'b1;
    #1 check_reset_outputs("reset_mid");
    @(negedge i_clk);
    i_reset = 1'b0;
    ref_acc = 8'h00;
    @(negedge i_clk);
    run(DEPTH, 1'b0, 1'b0, 10'h0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
